// File: rtl/systolic_os_ctrl_if.sv
// Command, operand-fetch, array-control and result handshake bundle for systolic_os_ctrl.
// master = command/consumer side, slave = the controller itself.
interface systolic_os_ctrl_if #(
   parameter int K_W = 8
) ();
   logic           start;
   logic [K_W-1:0] k_len;
   logic           abort;
   logic           busy;
   logic           done;
   logic           rd_en;
   logic [K_W-1:0] rd_idx;
   logic           reg_clear;
   logic           pipeline_en;
   logic           cell_en;
   logic           cell_sc_en;
   logic           c_switch;
   logic           cscan_en;
   logic           out_valid;
   logic           out_ready;

   modport master (
      output start, k_len, abort, out_ready,
      input  busy, done, rd_en, rd_idx, reg_clear, pipeline_en, cell_en,
             cell_sc_en, c_switch, cscan_en, out_valid
   );

   modport slave (
      input  start, k_len, abort, out_ready,
      output busy, done, rd_en, rd_idx, reg_clear, pipeline_en, cell_en,
             cell_sc_en, c_switch, cscan_en, out_valid
   );
endinterface

// File: rtl/systolic_os_ctrl.sv
// Clear/feed/drain/scan sequencer for an output-stationary systolic array.
// All outputs are registered alongside the state so they are glitch-free Moore outputs.
module systolic_os_ctrl #(
   parameter int X_AXIS = 3,
   parameter int Y_AXIS = 3,
   parameter int PE_LAT = 1,
   parameter int K_W    = 8
) (
   input logic               clk,
   input logic               rst_n,
   systolic_os_ctrl_if.slave bus
);
   // Drain covers the skew across the array plus the per-PE pipeline.
   localparam int D_CYC = X_AXIS + Y_AXIS - 2 + PE_LAT;
   localparam int D_W   = (D_CYC > 1) ? $clog2(D_CYC) : 1;
   localparam int CNT_W = (K_W > D_W) ? K_W : D_W;
   localparam logic [CNT_W-1:0] D_LAST = CNT_W'(D_CYC - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, SCAN} state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [K_W-1:0]   k_reg;
   logic [K_W-1:0]   rd_idx_reg;
   logic             busy_reg;
   logic             done_reg;
   logic             rd_en_reg;
   logic             reg_clear_reg;
   logic             pipeline_en_reg;
   logic             cell_en_reg;
   logic             cell_sc_en_reg;
   logic             cscan_en_reg;
   logic             out_valid_reg;
   logic [CNT_W-1:0] k_last;

   // k_reg is never 0 outside IDLE, so this never underflows where it is used.
   assign k_last = CNT_W'(k_reg) - CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         cnt_reg         <= '0;
         k_reg           <= '0;
         rd_idx_reg      <= '0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         rd_en_reg       <= 1'b0;
         reg_clear_reg   <= 1'b0;
         pipeline_en_reg <= 1'b0;
         cell_en_reg     <= 1'b0;
         cell_sc_en_reg  <= 1'b0;
         cscan_en_reg    <= 1'b0;
         out_valid_reg   <= 1'b0;
      end else if (bus.abort) begin
         state_reg       <= IDLE;
         cnt_reg         <= '0;
         rd_idx_reg      <= '0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         rd_en_reg       <= 1'b0;
         reg_clear_reg   <= 1'b0;
         pipeline_en_reg <= 1'b0;
         cell_en_reg     <= 1'b0;
         cell_sc_en_reg  <= 1'b0;
         cscan_en_reg    <= 1'b0;
         out_valid_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.start && (bus.k_len != '0)) begin
                  k_reg         <= bus.k_len;
                  state_reg     <= CLEAR;
                  busy_reg      <= 1'b1;
                  reg_clear_reg <= 1'b1;
               end
            end
            CLEAR: begin
               state_reg       <= FEED;
               cnt_reg         <= '0;
               rd_idx_reg      <= '0;
               reg_clear_reg   <= 1'b0;
               rd_en_reg       <= 1'b1;
               pipeline_en_reg <= 1'b1;
               cell_en_reg     <= 1'b1;
               cell_sc_en_reg  <= 1'b1;
            end
            FEED: begin
               if (cnt_reg == k_last) begin
                  state_reg      <= DRAIN;
                  cnt_reg        <= '0;
                  rd_en_reg      <= 1'b0;
                  cell_sc_en_reg <= 1'b0;
               end else begin
                  cnt_reg    <= cnt_reg + CNT_W'(1);
                  rd_idx_reg <= rd_idx_reg + K_W'(1);
               end
            end
            DRAIN: begin
               if (cnt_reg == D_LAST) begin
                  state_reg       <= SCAN;
                  cnt_reg         <= '0;
                  pipeline_en_reg <= 1'b0;
                  cell_en_reg     <= 1'b0;
                  cscan_en_reg    <= 1'b1;
                  out_valid_reg   <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            SCAN: begin
               if (bus.out_ready) begin
                  state_reg     <= IDLE;
                  busy_reg      <= 1'b0;
                  cscan_en_reg  <= 1'b0;
                  out_valid_reg <= 1'b0;
                  rd_idx_reg    <= '0;
                  done_reg      <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.busy        = busy_reg;
   assign bus.done        = done_reg;
   assign bus.rd_en       = rd_en_reg;
   assign bus.rd_idx      = rd_idx_reg;
   assign bus.reg_clear   = reg_clear_reg;
   assign bus.pipeline_en = pipeline_en_reg;
   assign bus.cell_en     = cell_en_reg;
   assign bus.cell_sc_en  = cell_sc_en_reg;
   assign bus.c_switch    = 1'b0;
   assign bus.cscan_en    = cscan_en_reg;
   assign bus.out_valid   = out_valid_reg;
endmodule

// File: tb/tb_systolic_os_ctrl.sv
// Scoreboard bench for systolic_os_ctrl: default instance (D=5) and a K_W=4, 4x4, PE_LAT=2 instance (D=8).
module tb_systolic_os_ctrl;
   localparam int D_A = 5;
   localparam int D_B = 8;
   localparam int EV_CLR = 0, EV_RD = 1, EV_DRN = 2, EV_VAL = 3, EV_DONE = 4;

   typedef struct {
      int dut;
      int kind;
      int data;
      int cyc;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   ev_t  exp_q[$];
   logic ov_prev_a = 1'b0;
   logic ov_prev_b = 1'b0;

   systolic_os_ctrl_if #(.K_W(8)) ifa ();
   systolic_os_ctrl_if #(.K_W(4)) ifb ();

   systolic_os_ctrl dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
   systolic_os_ctrl #(.X_AXIS(4), .Y_AXIS(4), .PE_LAT(2), .K_W(4))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [9:0] outs_a, outs_b;
   assign outs_a = {ifa.busy, ifa.done, ifa.rd_en, ifa.reg_clear, ifa.pipeline_en,
                    ifa.cell_en, ifa.cell_sc_en, ifa.c_switch, ifa.cscan_en, ifa.out_valid};
   assign outs_b = {ifb.busy, ifb.done, ifb.rd_en, ifb.reg_clear, ifb.pipeline_en,
                    ifb.cell_en, ifb.cell_sc_en, ifb.c_switch, ifb.cscan_en, ifb.out_valid};

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end else begin
         $display("ok   %s = 0x%0h (cycle %0d)", nm, act, cyc);
      end
   endtask

   task automatic push(input int dut, input int kind, input int data, input int c);
      ev_t e;
      e.dut = dut; e.kind = kind; e.data = data; e.cyc = c;
      exp_q.push_back(e);
   endtask

   // mode 0: full job; 1: up to out_valid (no done); 2: only n_drn drain cycles.
   task automatic push_job(input int dut, input int k, input int d, input int t0,
                           input int stall, input int mode, input int n_drn);
      int nd;
      nd = (mode == 2) ? n_drn : d;
      push(dut, EV_CLR, 0, t0 + 1);
      for (int i = 0; i < k; i++) push(dut, EV_RD, i + 256 * 7, t0 + 2 + i);
      for (int j = 0; j < nd; j++) push(dut, EV_DRN, 3, t0 + 2 + k + j);
      if (mode != 2) push(dut, EV_VAL, 1, t0 + 2 + k + d);
      if (mode == 0) push(dut, EV_DONE, 0, t0 + 3 + k + d + stall);
   endtask

   task automatic observe(input int dut, input int kind, input int data);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: dut %0d kind %0d data 0x%0h at cycle %0d, expected none",
                  dut, kind, data, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.dut != dut || e.kind != kind || e.data != data || e.cyc != cyc) begin
            errors++;
            $display("FAIL event: got dut %0d kind %0d data 0x%0h cycle %0d, expected dut %0d kind %0d data 0x%0h cycle %0d",
                     dut, kind, data, cyc, e.dut, e.kind, e.data, e.cyc);
         end else begin
            $display("ok   event dut %0d kind %0d data 0x%0h cycle %0d", dut, kind, data, cyc);
         end
      end
   endtask

   // Monitor: every observable transaction is matched against the scoreboard queue.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ifa.reg_clear) observe(0, EV_CLR, {ifa.rd_en, ifa.pipeline_en, ifa.cell_en, ifa.c_switch});
         if (ifa.rd_en) observe(0, EV_RD, int'(ifa.rd_idx) + 256 * int'({ifa.pipeline_en, ifa.cell_en, ifa.cell_sc_en}));
         if (ifa.pipeline_en && !ifa.rd_en) observe(0, EV_DRN, {ifa.cell_sc_en, ifa.cell_en, ifa.pipeline_en});
         if (ifa.out_valid && !ov_prev_a) observe(0, EV_VAL, {ifa.pipeline_en, ifa.cell_sc_en, ifa.cscan_en});
         if (ifa.done) observe(0, EV_DONE, {ifa.busy, ifa.out_valid});
         if (ifb.reg_clear) observe(1, EV_CLR, {ifb.rd_en, ifb.pipeline_en, ifb.cell_en, ifb.c_switch});
         if (ifb.rd_en) observe(1, EV_RD, int'(ifb.rd_idx) + 256 * int'({ifb.pipeline_en, ifb.cell_en, ifb.cell_sc_en}));
         if (ifb.pipeline_en && !ifb.rd_en) observe(1, EV_DRN, {ifb.cell_sc_en, ifb.cell_en, ifb.pipeline_en});
         if (ifb.out_valid && !ov_prev_b) observe(1, EV_VAL, {ifb.pipeline_en, ifb.cell_sc_en, ifb.cscan_en});
         if (ifb.done) observe(1, EV_DONE, {ifb.busy, ifb.out_valid});
      end
      ov_prev_a <= rst_n & ifa.out_valid;
      ov_prev_b <= rst_n & ifb.out_valid;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int dut, input int limit);
      int n = 0;
      while (((dut == 0) ? ifa.busy : ifb.busy) && n < limit) begin
         tick(1);
         n++;
      end
      check("wait_idle_busy", (dut == 0) ? ifa.busy : ifb.busy, 0);
      tick(2);
   endtask

   task automatic wait_valid_a(input int limit);
      int n = 0;
      while (!ifa.out_valid && n < limit) begin
         tick(1);
         n++;
      end
      check("wait_valid", ifa.out_valid, 1);
   endtask

   int t0;

   initial begin
      ifa.start = 0; ifa.k_len = '0; ifa.abort = 0; ifa.out_ready = 0;
      ifb.start = 0; ifb.k_len = '0; ifb.abort = 0; ifb.out_ready = 0;
      tick(3);
      check("reset_outs_a", outs_a, 0);
      check("reset_idx_a", ifa.rd_idx, 0);
      check("reset_outs_b", outs_b, 0);
      rst_n = 1'b1;
      tick(2);

      // Baseline job, k=4, downstream always ready.
      t0 = cyc; ifa.k_len = 8'd4; ifa.start = 1; ifa.out_ready = 1;
      push_job(0, 4, D_A, t0, 0, 0, 0);
      tick(1);
      ifa.start = 0; ifa.k_len = 8'hAA;
      check("t1_clear_cycle", {ifa.busy, ifa.reg_clear, ifa.rd_en, ifa.c_switch}, 4'b1100);
      wait_idle(0, 60);

      // k=1 with a 3-cycle consumer stall.
      ifa.out_ready = 0;
      t0 = cyc; ifa.k_len = 8'd1; ifa.start = 1;
      push_job(0, 1, D_A, t0, 3, 0, 0);
      tick(1);
      ifa.start = 0;
      wait_valid_a(40);
      for (int s = 0; s < 3; s++) begin
         check("stall_valid_cscan", {ifa.out_valid, ifa.cscan_en, ifa.busy, ifa.done}, 4'b1110);
         tick(1);
      end
      ifa.out_ready = 1;
      tick(1);
      ifa.out_ready = 0;
      wait_idle(0, 10);

      // k_len=0 is ignored; a start during FEED must not alter the job.
      ifa.out_ready = 1;
      ifa.k_len = 8'd0; ifa.start = 1;
      tick(1);
      ifa.start = 0;
      check("k0_ignored", outs_a, 0);
      tick(1);
      t0 = cyc; ifa.k_len = 8'd6; ifa.start = 1;
      push_job(0, 6, D_A, t0, 0, 0, 0);
      tick(1);
      ifa.start = 0;
      tick(2);
      ifa.k_len = 8'd2; ifa.start = 1;
      tick(1);
      ifa.start = 0;
      wait_idle(0, 60);

      // Abort in the second drain cycle together with a new start.
      t0 = cyc; ifa.k_len = 8'd2; ifa.start = 1;
      push_job(0, 2, D_A, t0, 0, 2, 2);
      tick(1);
      ifa.start = 0;
      tick(4);
      ifa.abort = 1; ifa.start = 1; ifa.k_len = 8'd3;
      tick(1);
      ifa.abort = 0; ifa.start = 0;
      check("abort_outs", outs_a, 0);
      check("abort_idx", ifa.rd_idx, 0);
      tick(4);
      check("abort_stays_idle", outs_a, 0);
      t0 = cyc; ifa.k_len = 8'd2; ifa.start = 1;
      push_job(0, 2, D_A, t0, 0, 0, 0);
      tick(1);
      ifa.start = 0;
      wait_idle(0, 40);

      // Asynchronous reset while waiting in SCAN.
      ifa.out_ready = 0;
      t0 = cyc; ifa.k_len = 8'd1; ifa.start = 1;
      push_job(0, 1, D_A, t0, 0, 1, 0);
      tick(1);
      ifa.start = 0;
      wait_valid_a(40);
      tick(1);
      check("scan_hold", {ifa.out_valid, ifa.cscan_en}, 2'b11);
      #1 rst_n = 1'b0;
      #1 check("async_reset_outs", outs_a, 0);
      #1 rst_n = 1'b1;
      tick(3);
      check("after_reset_idle", outs_a, 0);
      ifa.out_ready = 1;

      // Wide instance: 15 reads without index wrap, 8 drain cycles.
      ifb.out_ready = 1;
      t0 = cyc; ifb.k_len = 4'd15; ifb.start = 1;
      push_job(1, 15, D_B, t0, 0, 0, 0);
      tick(1);
      ifb.start = 0;
      wait_idle(1, 80);
      tick(2);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
